// File: rtl/can_oefm_pkg.sv
// Shared types and defaults for the CAN error/overload frame tracker.
package can_oefm_pkg;

    typedef enum logic [1:0] {
        PH_IDLE     = 2'd0,
        PH_FLAG     = 2'd1,
        PH_SUPERPOS = 2'd2,
        PH_DELIM    = 2'd3
    } phase_e;

    localparam logic FT_ERROR    = 1'b0;
    localparam logic FT_OVERLOAD = 1'b1;

    localparam int unsigned DEF_FLAG_LEN     = 6;
    localparam int unsigned DEF_DELIM_LEN    = 8;
    localparam int unsigned DEF_MAX_SUPERPOS = 14;
    localparam int unsigned DEF_MAX_OVLD     = 2;
    localparam int unsigned DEF_CNT_W        = 5;
    localparam int unsigned STAT_W           = 16;
    localparam int unsigned OVLD_CNT_W       = 2;

    // Chained-overload count increment that holds at all-ones.
    function automatic logic [OVLD_CNT_W-1:0] ovld_inc(input logic [OVLD_CNT_W-1:0] c);
        return (c == '1) ? c : c + OVLD_CNT_W'(1);
    endfunction

endpackage

// File: rtl/oefm_sat_counter.sv
// Saturating event counter with synchronous active-high reset.
module oefm_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             SP,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge SP) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/can_oe_frame_tracker.sv
// Error/overload frame tracker, one step per sample point.
// CAN_OEFM_STATS_EN builds the saturating frame/violation counters.
module can_oe_frame_tracker
    import can_oefm_pkg::*;
#(
    parameter int unsigned FLAG_LEN     = DEF_FLAG_LEN,
    parameter int unsigned DELIM_LEN    = DEF_DELIM_LEN,
    parameter int unsigned MAX_SUPERPOS = DEF_MAX_SUPERPOS,
    parameter int unsigned MAX_OVLD     = DEF_MAX_OVLD,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic              SP,
    input  logic              reset,
    input  logic              RX,
    input  logic              F_ERRw,
    input  logic              F_OVRLDw,
    input  logic              ERR_PASSIVEw,
    output logic              F_ITMSSw,
    output logic              BUSYw,
    output logic [1:0]        PHASEw,
    output logic              BIT_ERRw,
    output logic              FORM_ERRw,
    output logic              SUPERPOS_ERRw,
    output logic              OVLD_LIMw,
    output logic [1:0]        OVLD_CNTw,
    output logic [STAT_W-1:0] FRAME_CNTw,
    output logic [STAT_W-1:0] VIOL_CNTw
);

    phase_e           phase;
    logic [CNT_W-1:0] flag_cnt;
    logic [CNT_W-1:0] sp_cnt;
    logic [CNT_W-1:0] del_cnt;
    logic             passive;
    logic             last_rx;

    logic bit_err_c;
    logic form_err_c;
    logic sp_err_c;
    logic frame_done_c;
    logic ovld_chain_c;
    logic start_type_c;

    assign PHASEw = phase;

    // Per-bit events derived from the current phase and sampled bit.
    always_comb begin
        bit_err_c    = (phase == PH_FLAG) && !passive && RX;
        sp_err_c     = (phase == PH_SUPERPOS) && !RX
                       && (sp_cnt == CNT_W'(MAX_SUPERPOS - 1));
        form_err_c   = (phase == PH_DELIM) && !RX
                       && (del_cnt < CNT_W'(DELIM_LEN - 1));
        frame_done_c = (phase == PH_DELIM) && RX
                       && (del_cnt == CNT_W'(DELIM_LEN - 1));
        ovld_chain_c = (phase == PH_DELIM) && !RX
                       && (del_cnt == CNT_W'(DELIM_LEN - 1));
        start_type_c = F_ERRw ? FT_OVERLOAD : FT_ERROR;
    end

    always_ff @(posedge SP) begin
        if (reset) begin
            phase         <= PH_IDLE;
            BUSYw         <= 1'b0;
            F_ITMSSw      <= 1'b1;
            BIT_ERRw      <= 1'b0;
            FORM_ERRw     <= 1'b0;
            SUPERPOS_ERRw <= 1'b0;
            OVLD_LIMw     <= 1'b0;
            OVLD_CNTw     <= 2'd0;
            flag_cnt      <= '0;
            sp_cnt        <= '0;
            del_cnt       <= '0;
            passive       <= 1'b0;
            last_rx       <= 1'b1;
        end else begin
            F_ITMSSw      <= 1'b1;
            BIT_ERRw      <= bit_err_c;
            FORM_ERRw     <= form_err_c;
            SUPERPOS_ERRw <= sp_err_c;
            OVLD_LIMw     <= ovld_chain_c && ((32'(OVLD_CNTw) + 32'd1) > MAX_OVLD);

            case (phase)
                PH_IDLE: begin
                    if (!F_ERRw || !F_OVRLDw) begin
                        phase     <= PH_FLAG;
                        BUSYw     <= 1'b1;
                        passive   <= ERR_PASSIVEw;
                        last_rx   <= RX;
                        flag_cnt  <= CNT_W'(1);
                        OVLD_CNTw <= (start_type_c == FT_OVERLOAD) ? 2'd1 : 2'd0;
                    end
                end

                // Active flags restart on a recessive bit, passive ones on any edge.
                PH_FLAG: begin
                    last_rx <= RX;
                    if (passive ? (RX != last_rx) : RX) begin
                        flag_cnt <= CNT_W'(1);
                    end else if (flag_cnt == CNT_W'(FLAG_LEN - 1)) begin
                        phase  <= PH_SUPERPOS;
                        sp_cnt <= '0;
                    end else begin
                        flag_cnt <= flag_cnt + CNT_W'(1);
                    end
                end

                PH_SUPERPOS: begin
                    if (RX) begin
                        phase   <= PH_DELIM;
                        del_cnt <= CNT_W'(1);
                    end else if (sp_err_c) begin
                        sp_cnt <= '0;
                    end else begin
                        sp_cnt <= sp_cnt + CNT_W'(1);
                    end
                end

                // Dominant in the last delimiter bit chains a new overload frame.
                PH_DELIM: begin
                    if (frame_done_c) begin
                        phase     <= PH_IDLE;
                        BUSYw     <= 1'b0;
                        F_ITMSSw  <= 1'b0;
                        OVLD_CNTw <= 2'd0;
                    end else if (RX) begin
                        del_cnt <= del_cnt + CNT_W'(1);
                    end else if (ovld_chain_c) begin
                        phase     <= PH_FLAG;
                        passive   <= ERR_PASSIVEw;
                        last_rx   <= RX;
                        flag_cnt  <= CNT_W'(1);
                        OVLD_CNTw <= ovld_inc(OVLD_CNTw);
                    end else begin
                        phase  <= PH_SUPERPOS;
                        sp_cnt <= CNT_W'(1);
                    end
                end

                default: begin
                    phase <= PH_IDLE;
                    BUSYw <= 1'b0;
                end
            endcase
        end
    end

`ifdef CAN_OEFM_STATS_EN
    oefm_sat_counter #(.WIDTH(STAT_W)) u_frame_cnt (
        .SP    (SP),
        .reset (reset),
        .inc   (frame_done_c),
        .count (FRAME_CNTw)
    );

    oefm_sat_counter #(.WIDTH(STAT_W)) u_viol_cnt (
        .SP    (SP),
        .reset (reset),
        .inc   (bit_err_c | form_err_c | sp_err_c),
        .count (VIOL_CNTw)
    );
`else
    assign FRAME_CNTw = '0;
    assign VIOL_CNTw  = '0;
`endif

endmodule

// File: tb/tb_can_oe_frame_tracker.sv
// Scoreboard bench for can_oe_frame_tracker with default parameters.
module tb_can_oe_frame_tracker;

    typedef struct packed {
        logic [1:0]  phase;
        logic        busy;
        logic        itm;
        logic        bit_e;
        logic        form_e;
        logic        sp_e;
        logic        lim;
        logic [1:0]  ocnt;
        logic [15:0] fc;
        logic [15:0] vc;
    } obs_t;

    logic        SP = 1'b0;
    logic        reset = 1'b1;
    logic        RX = 1'b1;
    logic        F_ERRw = 1'b1;
    logic        F_OVRLDw = 1'b1;
    logic        ERR_PASSIVEw = 1'b0;
    logic        F_ITMSSw, BUSYw, BIT_ERRw, FORM_ERRw, SUPERPOS_ERRw, OVLD_LIMw;
    logic [1:0]  PHASEw, OVLD_CNTw;
    logic [15:0] FRAME_CNTw, VIOL_CNTw;

    int checks = 0;
    int errors = 0;
    obs_t sb[$];

    // Reference model state
    int m_phase = 0, m_run = 0, m_dom = 0, m_dbit = 0, m_ovl = 0;
    int m_frames = 0, m_viol = 0;
    logic m_prev = 1'b1, m_pas = 1'b0;

    can_oe_frame_tracker dut (
        .SP(SP), .reset(reset), .RX(RX), .F_ERRw(F_ERRw), .F_OVRLDw(F_OVRLDw),
        .ERR_PASSIVEw(ERR_PASSIVEw), .F_ITMSSw(F_ITMSSw), .BUSYw(BUSYw),
        .PHASEw(PHASEw), .BIT_ERRw(BIT_ERRw), .FORM_ERRw(FORM_ERRw),
        .SUPERPOS_ERRw(SUPERPOS_ERRw), .OVLD_LIMw(OVLD_LIMw), .OVLD_CNTw(OVLD_CNTw),
        .FRAME_CNTw(FRAME_CNTw), .VIOL_CNTw(VIOL_CNTw)
    );

    always #5 SP = ~SP;

    function automatic obs_t sample();
        return '{PHASEw, BUSYw, F_ITMSSw, BIT_ERRw, FORM_ERRw, SUPERPOS_ERRw,
                 OVLD_LIMw, OVLD_CNTw, FRAME_CNTw, VIOL_CNTw};
    endfunction

    // Bit-level behaviour with the default lengths 6/8/14/2.
    task automatic model_step(input logic rx, input logic ferr, input logic fovl,
                              input logic pas, input logic rst, output obs_t e);
        e = '0;
        e.itm = 1'b1;
        if (rst) begin
            m_phase = 0; m_ovl = 0; m_frames = 0; m_viol = 0;
        end else begin
            case (m_phase)
                0: if (!ferr || !fovl) begin
                    m_phase = 1; m_pas = pas; m_prev = rx; m_run = 1;
                    m_ovl = ferr ? 1 : 0;
                end
                1: begin
                    if (!m_pas && rx) begin
                        e.bit_e = 1'b1; m_run = 1;
                    end else if (m_pas && (rx != m_prev)) begin
                        m_run = 1;
                    end else begin
                        m_run++;
                        if (m_run == 6) begin m_phase = 2; m_dom = 0; end
                    end
                    m_prev = rx;
                end
                2: if (rx) begin
                    m_phase = 3; m_dbit = 1;
                end else begin
                    m_dom++;
                    if (m_dom == 14) begin e.sp_e = 1'b1; m_dom = 0; end
                end
                default: begin
                    if (rx) begin
                        m_dbit++;
                        if (m_dbit == 8) begin
                            m_phase = 0; e.itm = 1'b0; m_ovl = 0;
                            if (m_frames < 65535) m_frames++;
                        end
                    end else if (m_dbit == 7) begin
                        m_phase = 1; m_run = 1; m_prev = rx; m_pas = pas;
                        m_ovl++;
                        if (m_ovl > 2) e.lim = 1'b1;
                        if (m_ovl > 3) m_ovl = 3;
                    end else begin
                        e.form_e = 1'b1; m_phase = 2; m_dom = 1;
                    end
                end
            endcase
            if ((e.bit_e || e.form_e || e.sp_e) && m_viol < 65535) m_viol++;
        end
        e.phase = 2'(m_phase);
        e.busy  = (m_phase != 0);
        e.ocnt  = 2'(m_ovl);
`ifdef CAN_OEFM_STATS_EN
        e.fc = 16'(m_frames);
        e.vc = 16'(m_viol);
`endif
    endtask

    // Apply one bit away from the edge, queue its expectation, land just after the edge.
    task automatic drive(input logic rx, input logic ferr, input logic fovl,
                         input logic pas, input logic rst);
        obs_t e;
        @(negedge SP);
        RX = rx; F_ERRw = ferr; F_OVRLDw = fovl; ERR_PASSIVEw = pas; reset = rst;
        model_step(rx, ferr, fovl, pas, rst, e);
        sb.push_back(e);
        @(posedge SP);
        #1;
    endtask

    task automatic test_reset();
        obs_t exp_o;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            exp_o = sb.pop_front();
            checks++;
            if (sample() !== exp_o) begin
                errors++;
                $display("FAIL reset step %0d: got %h expected %h", i, sample(), exp_o);
            end
        end
        checks++;
        if (PHASEw !== 2'd0 || F_ITMSSw !== 1'b1 || BUSYw !== 1'b0 || OVLD_CNTw !== 2'd0) begin
            errors++;
            $display("FAIL reset_values: got phase=%0d itm=%b busy=%b ocnt=%0d expected 0 1 0 0",
                     PHASEw, F_ITMSSw, BUSYw, OVLD_CNTw);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_o = sb.pop_front();
        checks++;
        if (sample() !== exp_o) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", sample(), exp_o);
        end
    endtask

    task automatic test_active_error();
        obs_t exp_o;
        logic [1:0] ph_lit [14] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3,
                                    2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
        for (int i = 0; i < 14; i++) begin
            drive(i >= 6, (i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0);
            exp_o = sb.pop_front();
            checks++;
            if (sample() !== exp_o) begin
                errors++;
                $display("FAIL active_err step %0d: got %h expected %h", i, sample(), exp_o);
            end
            checks++;
            if (PHASEw !== ph_lit[i] || F_ITMSSw !== (i != 13)) begin
                errors++;
                $display("FAIL active_err_phase step %0d: got phase=%0d itm=%b expected phase=%0d itm=%b",
                         i, PHASEw, F_ITMSSw, ph_lit[i], (i != 13));
            end
        end
    endtask

    task automatic test_bit_error();
        obs_t exp_o;
        // flag bits 1..3 (bit 3 recessive), restart run of 5 more, then delimiter; overload request ignored
        logic rx_seq [16] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        for (int i = 0; i < 16; i++) begin
            drive(rx_seq[i], (i == 0) ? 1'b0 : 1'b1, (i == 4) ? 1'b0 : 1'b1, 1'b0, 1'b0);
            exp_o = sb.pop_front();
            checks++;
            if (sample() !== exp_o) begin
                errors++;
                $display("FAIL bit_err step %0d: got %h expected %h", i, sample(), exp_o);
            end
            checks++;
            if (BIT_ERRw !== (i == 2)) begin
                errors++;
                $display("FAIL bit_err_pulse step %0d: got %b expected %b", i, BIT_ERRw, (i == 2));
            end
        end
    endtask

    task automatic test_passive();
        obs_t exp_o;
        logic rx_seq [15] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        for (int i = 0; i < 15; i++) begin
            drive(rx_seq[i], (i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b0);
            exp_o = sb.pop_front();
            checks++;
            if (sample() !== exp_o) begin
                errors++;
                $display("FAIL passive step %0d: got %h expected %h", i, sample(), exp_o);
            end
            if (i == 6 || i == 7) begin
                checks++;
                if (PHASEw !== ((i == 7) ? 2'd2 : 2'd1) || BIT_ERRw !== 1'b0) begin
                    errors++;
                    $display("FAIL passive_end step %0d: got phase=%0d bit_err=%b", i, PHASEw, BIT_ERRw);
                end
            end
        end
    endtask

    task automatic test_superpos();
        obs_t exp_o;
        for (int i = 0; i < 28; i++) begin
            drive(i >= 20, (i == 0) ? 1'b1 : 1'b1, (i == 0) ? 1'b0 : 1'b1, 1'b0, 1'b0);
            exp_o = sb.pop_front();
            checks++;
            if (sample() !== exp_o) begin
                errors++;
                $display("FAIL superpos step %0d: got %h expected %h", i, sample(), exp_o);
            end
            checks++;
            if (SUPERPOS_ERRw !== (i == 19) || (i == 19 && PHASEw !== 2'd2)
                || F_ITMSSw !== (i != 27)) begin
                errors++;
                $display("FAIL superpos_pulse step %0d: got sp_err=%b phase=%0d itm=%b",
                         i, SUPERPOS_ERRw, PHASEw, F_ITMSSw);
            end
        end
    endtask

    task automatic test_overload_chain();
        obs_t exp_o;
        logic rx_seq [$];
        // error flag, then three chained overloads via dominant delimiter bit 8
        for (int k = 0; k < 6; k++) rx_seq.push_back(1'b0);
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 7; k++) rx_seq.push_back(1'b1);
            rx_seq.push_back(1'b0);
            for (int k = 0; k < 5; k++) rx_seq.push_back(1'b0);
        end
        // dominant at delimiter bit 4, then recover
        for (int k = 0; k < 3; k++) rx_seq.push_back(1'b1);
        rx_seq.push_back(1'b0);
        for (int k = 0; k < 8; k++) rx_seq.push_back(1'b1);
        for (int i = 0; i < rx_seq.size(); i++) begin
            drive(rx_seq[i], (i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0);
            exp_o = sb.pop_front();
            checks++;
            if (sample() !== exp_o) begin
                errors++;
                $display("FAIL ovld_chain step %0d: got %h expected %h", i, sample(), exp_o);
            end
            if (i == 13 || i == 26 || i == 39) begin
                checks++;
                if (OVLD_CNTw !== 2'((i - 13) / 13 + 1) || OVLD_LIMw !== (i == 39)) begin
                    errors++;
                    $display("FAIL ovld_count step %0d: got cnt=%0d lim=%b", i, OVLD_CNTw, OVLD_LIMw);
                end
            end
            if (i == 48) begin
                checks++;
                if (FORM_ERRw !== 1'b1 || PHASEw !== 2'd2) begin
                    errors++;
                    $display("FAIL form_err: got form=%b phase=%0d expected 1 2", FORM_ERRw, PHASEw);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t exp_o;
        logic [15:0] fc_lit;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        exp_o = sb.pop_front();
        checks++;
        if (sample() !== exp_o) begin
            errors++;
            $display("FAIL b2b_reset: got %h expected %h", sample(), exp_o);
        end
        for (int i = 0; i < 28; i++) begin
            drive((i % 14) >= 6, ((i % 14) == 0) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0);
            exp_o = sb.pop_front();
            checks++;
            if (sample() !== exp_o) begin
                errors++;
                $display("FAIL b2b step %0d: got %h expected %h", i, sample(), exp_o);
            end
        end
`ifdef CAN_OEFM_STATS_EN
        fc_lit = 16'd2;
`else
        fc_lit = 16'd0;
`endif
        checks++;
        if (FRAME_CNTw !== fc_lit) begin
            errors++;
            $display("FAIL frame_cnt: got %0d expected %0d", FRAME_CNTw, fc_lit);
        end
        // reset lands on flag bit 4 together with a new trigger
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, (i == 0 || i == 3) ? 1'b0 : 1'b1, 1'b1, 1'b0, (i == 3));
            exp_o = sb.pop_front();
            checks++;
            if (sample() !== exp_o) begin
                errors++;
                $display("FAIL midreset step %0d: got %h expected %h", i, sample(), exp_o);
            end
            if (i >= 3) begin
                checks++;
                if (PHASEw !== 2'd0 || F_ITMSSw !== 1'b1 || BUSYw !== 1'b0 || FRAME_CNTw !== 16'd0) begin
                    errors++;
                    $display("FAIL midreset_idle step %0d: got phase=%0d itm=%b busy=%b fc=%0d",
                             i, PHASEw, F_ITMSSw, BUSYw, FRAME_CNTw);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_active_error();
        test_bit_error();
        test_passive();
        test_superpos();
        test_overload_chain();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
